// File: rtl/cache_axi_arbiter.sv
`timescale 1ns/1ps
// Merges the I-cache read master and D-cache read/write master onto one AXI3 master port.
// Define ARB_RR_EN for round-robin read arbitration; by default the D-cache wins every tie.
module cache_axi_arbiter #(
  parameter logic [3:0] I_ID = 4'd0,
  parameter logic [3:0] D_ID = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  // I-cache read master
  input  logic [31:0] i_araddr,
  input  logic [7:0]  i_arlen,
  input  logic [2:0]  i_arsize,
  input  logic        i_arvalid,
  output logic        i_arready,
  output logic [31:0] i_rdata,
  output logic        i_rlast,
  output logic        i_rvalid,
  input  logic        i_rready,
  // D-cache read master
  input  logic [31:0] d_araddr,
  input  logic [7:0]  d_arlen,
  input  logic [2:0]  d_arsize,
  input  logic        d_arvalid,
  output logic        d_arready,
  output logic [31:0] d_rdata,
  output logic        d_rlast,
  output logic        d_rvalid,
  input  logic        d_rready,
  // D-cache write master
  input  logic [31:0] d_awaddr,
  input  logic [7:0]  d_awlen,
  input  logic [2:0]  d_awsize,
  input  logic        d_awvalid,
  output logic        d_awready,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  input  logic        d_wlast,
  input  logic        d_wvalid,
  output logic        d_wready,
  output logic        d_bvalid,
  input  logic        d_bready,
  // AXI3 master port
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [1:0] {RIdle, RAr, RData} rd_state_e;
  typedef enum logic [1:0] {WIdle, WAw, WData, WResp} wr_state_e;

  rd_state_e rd_state_q;
  wr_state_e wr_state_q;
  logic      rd_owner_q;  // 1: D-cache owns the read channel
  logic      grant_d;
  logic      rd_data_phase;
  logic      unused_resp;

  // Response ids/codes are not forwarded to the caches.
  assign unused_resp = ^{rid, rresp, bid, bresp};

`ifdef ARB_RR_EN
  logic last_grant_q;  // 1: D-cache was granted last

  always_comb begin
    if (i_arvalid && d_arvalid) grant_d = ~last_grant_q;
    else                        grant_d = d_arvalid;
  end
`else
  assign grant_d = d_arvalid;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_q <= RIdle;
      rd_owner_q <= 1'b0;
      i_arready  <= 1'b0;
      d_arready  <= 1'b0;
      arvalid    <= 1'b0;
      arid       <= '0;
      araddr     <= '0;
      arlen      <= '0;
      arsize     <= '0;
`ifdef ARB_RR_EN
      last_grant_q <= 1'b0;
`endif
    end else begin
      i_arready <= 1'b0;
      d_arready <= 1'b0;
      unique case (rd_state_q)
        RIdle: begin
          if (i_arvalid || d_arvalid) begin
            rd_owner_q <= grant_d;
            i_arready  <= ~grant_d;
            d_arready  <= grant_d;
            arid       <= grant_d ? D_ID : I_ID;
            araddr     <= grant_d ? d_araddr : i_araddr;
            arlen      <= grant_d ? d_arlen : i_arlen;
            arsize     <= grant_d ? d_arsize : i_arsize;
            arvalid    <= 1'b1;
            rd_state_q <= RAr;
`ifdef ARB_RR_EN
            last_grant_q <= grant_d;
`endif
          end
        end
        RAr: begin
          if (arready) begin
            arvalid    <= 1'b0;
            rd_state_q <= RData;
          end
        end
        RData: begin
          if (rvalid && rready && rlast) rd_state_q <= RIdle;
        end
        default: rd_state_q <= RIdle;
      endcase
    end
  end

  assign rd_data_phase = (rd_state_q == RData);
  assign rready   = rd_data_phase & (rd_owner_q ? d_rready : i_rready);
  assign i_rvalid = rd_data_phase & ~rd_owner_q & rvalid;
  assign d_rvalid = rd_data_phase & rd_owner_q & rvalid;
  assign i_rlast  = rd_data_phase & ~rd_owner_q & rlast;
  assign d_rlast  = rd_data_phase & rd_owner_q & rlast;
  assign i_rdata  = rdata;
  assign d_rdata  = rdata;
  assign arburst  = 2'b01;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_q <= WIdle;
      d_awready  <= 1'b0;
      awvalid    <= 1'b0;
      awid       <= '0;
      awaddr     <= '0;
      awlen      <= '0;
      awsize     <= '0;
    end else begin
      d_awready <= 1'b0;
      unique case (wr_state_q)
        WIdle: begin
          if (d_awvalid) begin
            d_awready  <= 1'b1;
            awid       <= D_ID;
            awaddr     <= d_awaddr;
            awlen      <= d_awlen;
            awsize     <= d_awsize;
            awvalid    <= 1'b1;
            wr_state_q <= WAw;
          end
        end
        WAw: begin
          if (awready) begin
            awvalid    <= 1'b0;
            wr_state_q <= WData;
          end
        end
        WData: begin
          if (d_wvalid && wready && d_wlast) wr_state_q <= WResp;
        end
        WResp: begin
          if (bvalid && d_bready) wr_state_q <= WIdle;
        end
        default: wr_state_q <= WIdle;
      endcase
    end
  end

  assign wvalid   = (wr_state_q == WData) & d_wvalid;
  assign d_wready = (wr_state_q == WData) & wready;
  assign wdata    = d_wdata;
  assign wstrb    = d_wstrb;
  assign wlast    = d_wlast;
  assign bready   = (wr_state_q == WResp) & d_bready;
  assign d_bvalid = (wr_state_q == WResp) & bvalid;
  assign awburst  = 2'b01;

endmodule

// File: tb/tb_cache_axi_arbiter.sv
`timescale 1ns/1ps
// Directed bench for cache_axi_arbiter: cache masters driven from one sequence, AXI slave modelled.
module tb_cache_axi_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] i_araddr, d_araddr, d_awaddr, d_wdata;
  logic [7:0]  i_arlen, d_arlen, d_awlen;
  logic [2:0]  i_arsize, d_arsize, d_awsize;
  logic        i_arvalid, i_arready, i_rlast, i_rvalid, i_rready;
  logic        d_arvalid, d_arready, d_rlast, d_rvalid, d_rready;
  logic [31:0] i_rdata, d_rdata;
  logic        d_awvalid, d_awready, d_wlast, d_wvalid, d_wready, d_bvalid, d_bready;
  logic [3:0]  d_wstrb;
  logic [3:0]  arid, awid, rid, bid, wstrb;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  cache_axi_arbiter dut (
    .clk(clk), .rst(rst),
    .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arsize(i_arsize),
    .i_arvalid(i_arvalid), .i_arready(i_arready),
    .i_rdata(i_rdata), .i_rlast(i_rlast), .i_rvalid(i_rvalid), .i_rready(i_rready),
    .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arsize(d_arsize),
    .d_arvalid(d_arvalid), .d_arready(d_arready),
    .d_rdata(d_rdata), .d_rlast(d_rlast), .d_rvalid(d_rvalid), .d_rready(d_rready),
    .d_awaddr(d_awaddr), .d_awlen(d_awlen), .d_awsize(d_awsize),
    .d_awvalid(d_awvalid), .d_awready(d_awready),
    .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_wlast(d_wlast),
    .d_wvalid(d_wvalid), .d_wready(d_wready), .d_bvalid(d_bvalid), .d_bready(d_bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- AXI slave model: read side ----------------
  int          ar_stall = 0;
  int          ar_wait = 0;
  bit          rd_busy = 0;
  int          rd_cnt = 0, rd_len = 0;
  logic [31:0] rd_base = '0;
  int          ar_fire_cyc = -1;
  logic [3:0]  ar_log_id[$];
  logic [31:0] ar_log_addr[$];

  initial begin
    bit s_rst, s_ar, s_arv, s_r;
    logic [3:0]  s_id;
    logic [31:0] s_addr;
    logic [7:0]  s_len;
    arready = 0; rvalid = 0; rdata = '0; rlast = 0; rid = '0; rresp = '0;
    forever begin
      @(negedge clk);
      s_rst = rst; s_ar = arvalid && arready; s_arv = arvalid; s_r = rvalid && rready;
      s_id = arid; s_addr = araddr; s_len = arlen;
      @(posedge clk); #1;
      if (s_rst) begin
        rd_busy = 0; arready = 0; rvalid = 0; rlast = 0; ar_wait = 0;
      end else begin
        if (s_r) begin
          if (rd_cnt == rd_len) rd_busy = 0;
          else rd_cnt++;
        end
        if (s_ar) begin
          rd_busy = 1; rd_cnt = 0; rd_len = int'(s_len); rd_base = s_addr; arready = 0;
          ar_log_id.push_back(s_id); ar_log_addr.push_back(s_addr); ar_fire_cyc = cyc;
        end else if (s_arv && !arready && !rd_busy) begin
          if (ar_wait >= ar_stall) begin arready = 1; ar_wait = 0; end
          else ar_wait++;
        end
        rvalid = rd_busy;
        rdata  = rd_base + (32'(rd_cnt) << 2);
        rlast  = rd_busy && (rd_cnt == rd_len);
      end
    end
  end

  // ---------------- AXI slave model: write side ----------------
  bit          wr_busy = 0;
  int          aw_fire_cyc = -1;
  logic [3:0]  aw_log_id = '0;
  logic [31:0] aw_log_addr = '0;
  logic [7:0]  aw_log_len = '0;
  logic [31:0] w_data_q[$];
  logic [3:0]  w_strb_q[$];
  logic        w_last_q[$];

  initial begin
    bit s_rst, s_aw, s_awv, s_w, s_b, s_wl;
    logic [3:0]  s_id, s_strb;
    logic [31:0] s_addr, s_data;
    logic [7:0]  s_len;
    awready = 0; wready = 0; bvalid = 0; bid = '0; bresp = '0;
    forever begin
      @(negedge clk);
      s_rst = rst; s_aw = awvalid && awready; s_awv = awvalid;
      s_w = wvalid && wready; s_b = bvalid && bready;
      s_id = awid; s_addr = awaddr; s_len = awlen; s_data = wdata; s_strb = wstrb; s_wl = wlast;
      @(posedge clk); #1;
      if (s_rst) begin
        wr_busy = 0; awready = 0; wready = 0; bvalid = 0;
      end else begin
        if (s_b) bvalid = 0;
        if (s_w) begin
          w_data_q.push_back(s_data); w_strb_q.push_back(s_strb); w_last_q.push_back(s_wl);
          if (s_wl) begin wr_busy = 0; bvalid = 1; end
        end
        if (s_aw) begin
          wr_busy = 1; awready = 0; aw_fire_cyc = cyc;
          aw_log_id = s_id; aw_log_addr = s_addr; aw_log_len = s_len;
        end else if (s_awv && !awready && !wr_busy && !bvalid) begin
          awready = 1;
        end
        wready = wr_busy;
      end
    end
  end

  // ---------------- cache-side monitor ----------------
  logic [32:0] i_q[$];
  logic [32:0] d_q[$];
  int d_rvalid_seen = 0;
  int b_cnt = 0;

  always @(negedge clk) begin
    if (i_rvalid && i_rready) i_q.push_back({i_rlast, i_rdata});
    if (d_rvalid && d_rready) d_q.push_back({d_rlast, d_rdata});
    if (d_rvalid) d_rvalid_seen++;
    if (d_bvalid && d_bready) b_cnt++;
  end

  // ---------------- helpers ----------------
  task automatic grant_wait(output int who);
    who = -1;
    for (int k = 0; k < 50 && who < 0; k++) begin
      @(negedge clk);
      if (d_arready) who = 1;
      else if (i_arready) who = 0;
    end
  endtask

  task automatic wait_beats(input bit is_d, input int n, input string tag);
    int got;
    got = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      got = is_d ? d_q.size() : i_q.size();
      if (got >= n) break;
    end
    check({tag, "_beats"}, 32'(got), 32'(n));
  endtask

  task automatic check_beats(input bit is_d, input logic [31:0] base, input int n,
                             input string tag);
    logic [32:0] e;
    for (int k = 0; k < n; k++) begin
      e = '1;
      if (is_d && k < d_q.size()) e = d_q[k];
      if (!is_d && k < i_q.size()) e = i_q[k];
      check($sformatf("%s_data%0d", tag, k), e[31:0], base + (32'(k) << 2));
      check($sformatf("%s_last%0d", tag, k), 32'(e[32]), 32'(k == n - 1));
    end
  endtask

  task automatic do_read(input bit is_d, input logic [31:0] addr, input logic [7:0] len,
                         input int hold, input string tag);
    int who;
    if (is_d) begin
      d_q.delete(); d_araddr = addr; d_arlen = len; d_arsize = 3'd2; d_arvalid = 1;
    end else begin
      i_q.delete(); i_araddr = addr; i_arlen = len; i_arsize = 3'd2; i_arvalid = 1;
    end
    grant_wait(who);
    check({tag, "_who"}, 32'(who), 32'(is_d));
    check({tag, "_arid"}, 32'(arid), is_d ? 32'd1 : 32'd0);
    check({tag, "_araddr"}, araddr, addr);
    @(posedge clk); #1;
    if (is_d) d_arvalid = 0; else i_arvalid = 0;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check($sformatf("%s_hold_arvalid%0d", tag, k), 32'(arvalid), 32'd1);
      check($sformatf("%s_hold_araddr%0d", tag, k), araddr, addr);
      check($sformatf("%s_hold_arlen%0d", tag, k), 32'(arlen), 32'(len));
      check($sformatf("%s_hold_arid%0d", tag, k), 32'(arid), is_d ? 32'd1 : 32'd0);
    end
    wait_beats(is_d, int'(len) + 1, tag);
    check_beats(is_d, addr, int'(len) + 1, tag);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input string tag);
    int b0;
    bit seen;
    b0 = b_cnt;
    d_awaddr = addr; d_awlen = len; d_awsize = 3'd2; d_awvalid = 1;
    seen = 0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      seen = d_awready;
    end
    check({tag, "_awready"}, 32'(seen), 32'd1);
    @(posedge clk); #1;
    d_awvalid = 0;
    for (int b = 0; b <= int'(len); b++) begin
      d_wdata = 32'hA5A5_0000 + 32'(b); d_wstrb = 4'hF; d_wlast = (b == int'(len)); d_wvalid = 1;
      seen = 0;
      for (int k = 0; k < 50 && !seen; k++) begin
        @(negedge clk);
        seen = d_wready;
      end
      check($sformatf("%s_wready%0d", tag, b), 32'(seen), 32'd1);
      @(posedge clk); #1;
    end
    d_wvalid = 0; d_wlast = 0;
    for (int k = 0; k < 50 && b_cnt == b0; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    check({tag, "_bpulses"}, 32'(b_cnt - b0), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int who;
    int d0;
    int exp3[3];
    rst = 1;
    i_araddr = '0; i_arlen = '0; i_arsize = '0; i_arvalid = 0; i_rready = 1;
    d_araddr = '0; d_arlen = '0; d_arsize = '0; d_arvalid = 0; d_rready = 1;
    d_awaddr = '0; d_awlen = '0; d_awsize = '0; d_awvalid = 0;
    d_wdata = '0; d_wstrb = '0; d_wlast = 0; d_wvalid = 0; d_bready = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;

    // Reset state
    @(negedge clk);
    check("rst_arvalid", 32'(arvalid), 0);
    check("rst_awvalid", 32'(awvalid), 0);
    check("rst_wvalid", 32'(wvalid), 0);
    check("rst_rready", 32'(rready), 0);
    check("rst_bready", 32'(bready), 0);
    check("rst_i_arready", 32'(i_arready), 0);
    check("rst_d_arready", 32'(d_arready), 0);
    check("rst_d_awready", 32'(d_awready), 0);
    check("rst_d_wready", 32'(d_wready), 0);
    check("rst_i_rvalid", 32'(i_rvalid), 0);
    check("rst_d_rvalid", 32'(d_rvalid), 0);
    check("rst_d_bvalid", 32'(d_bvalid), 0);
    check("rst_arid", 32'(arid), 0);
    check("rst_araddr", araddr, 0);
    check("rst_arburst", 32'(arburst), 32'd1);
    check("rst_awburst", 32'(awburst), 32'd1);

    // 1: I-cache alone, 8-beat burst, arvalid one cycle after the request
    @(posedge clk); #1;
    d0 = d_rvalid_seen;
    i_q.delete();
    i_araddr = 32'hBFC0_0000; i_arlen = 8'd7; i_arsize = 3'd2; i_arvalid = 1;
    @(negedge clk);
    check("t1_arvalid_n", 32'(arvalid), 0);
    @(negedge clk);
    check("t1_arvalid_n1", 32'(arvalid), 1);
    check("t1_i_arready", 32'(i_arready), 1);
    check("t1_d_arready", 32'(d_arready), 0);
    check("t1_arid", 32'(arid), 0);
    check("t1_araddr", araddr, 32'hBFC0_0000);
    check("t1_arlen", 32'(arlen), 32'd7);
    check("t1_arsize", 32'(arsize), 32'd2);
    @(posedge clk); #1;
    i_arvalid = 0;
    wait_beats(0, 8, "t1");
    check_beats(0, 32'hBFC0_0000, 8, "t1");
    check("t1_d_rvalid_quiet", 32'(d_rvalid_seen - d0), 0);

    // 2: simultaneous requests, D wins first, I served after D's last beat
    @(posedge clk); #1;
    i_q.delete(); d_q.delete();
    i_araddr = 32'h0000_1000; i_arlen = 8'd1; i_arsize = 3'd2; i_arvalid = 1;
    d_araddr = 32'h0000_2000; d_arlen = 8'd1; d_arsize = 3'd2; d_arvalid = 1;
    grant_wait(who);
    check("t2_first_who", 32'(who), 32'd1);
    check("t2_first_arid", 32'(arid), 32'd1);
    check("t2_first_araddr", araddr, 32'h0000_2000);
    @(posedge clk); #1;
    d_arvalid = 0;
    grant_wait(who);
    check("t2_second_who", 32'(who), 32'd0);
    check("t2_second_arid", 32'(arid), 32'd0);
    check("t2_d_done_before_i", 32'(d_q.size()), 32'd2);
    @(posedge clk); #1;
    i_arvalid = 0;
    wait_beats(0, 2, "t2i");
    check_beats(1, 32'h0000_2000, 2, "t2d");
    check_beats(0, 32'h0000_1000, 2, "t2i");

    // 3: three back-to-back tie rounds
`ifdef ARB_RR_EN
    exp3[0] = 1; exp3[1] = 0; exp3[2] = 1;
`else
    exp3[0] = 1; exp3[1] = 1; exp3[2] = 1;
`endif
    for (int r = 0; r < 3; r++) begin
      @(posedge clk); #1;
      i_q.delete(); d_q.delete();
      i_araddr = 32'h0000_7000 + 32'(r * 16); i_arlen = 8'd0; i_arvalid = 1;
      d_araddr = 32'h0000_7800 + 32'(r * 16); d_arlen = 8'd0; d_arvalid = 1;
      grant_wait(who);
      check($sformatf("t3_round%0d_who", r), 32'(who), 32'(exp3[r]));
      check($sformatf("t3_round%0d_arid", r), 32'(arid), 32'(exp3[r]));
      @(posedge clk); #1;
      i_arvalid = 0; d_arvalid = 0;
      wait_beats(exp3[r] == 1, 1, $sformatf("t3_round%0d", r));
      check($sformatf("t3_round%0d_loser_quiet", r),
            32'(exp3[r] == 1 ? i_q.size() : d_q.size()), 0);
    end

    // 4: D write concurrent with I read
    @(posedge clk); #1;
    w_data_q.delete(); w_strb_q.delete(); w_last_q.delete();
    fork
      do_read(0, 32'h0000_3000, 8'd3, 0, "t4r");
      do_write(32'h8000_1000, 8'd3, "t4w");
    join
    check("t4_awid", 32'(aw_log_id), 32'd1);
    check("t4_awaddr", aw_log_addr, 32'h8000_1000);
    check("t4_awlen", 32'(aw_log_len), 32'd3);
    check("t4_same_cycle_ar_aw", 32'(ar_fire_cyc), 32'(aw_fire_cyc));
    check("t4_wbeats", 32'(w_data_q.size()), 32'd4);
    for (int b = 0; b < 4 && b < w_data_q.size(); b++) begin
      check($sformatf("t4_wdata%0d", b), w_data_q[b], 32'hA5A5_0000 + 32'(b));
      check($sformatf("t4_wstrb%0d", b), 32'(w_strb_q[b]), 32'hF);
      check($sformatf("t4_wlast%0d", b), 32'(w_last_q[b]), 32'(b == 3));
    end

    // 5: arready stalled, single-beat burst
    @(posedge clk); #1;
    ar_stall = 5;
    do_read(0, 32'h0000_4000, 8'd0, 5, "t5");
    ar_stall = 0;

    // 6: reset during beat 3 of 8, then a fresh request
    @(posedge clk); #1;
    i_q.delete();
    i_araddr = 32'h0000_5000; i_arlen = 8'd7; i_arsize = 3'd2; i_arvalid = 1;
    grant_wait(who);
    check("t6_who", 32'(who), 32'd0);
    @(posedge clk); #1;
    i_arvalid = 0;
    for (int k = 0; k < 100 && i_q.size() < 2; k++) @(negedge clk);
    check("t6_beats_before_rst", 32'(i_q.size()), 32'd2);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check("t6_arvalid", 32'(arvalid), 0);
    check("t6_i_rvalid", 32'(i_rvalid), 0);
    check("t6_d_rvalid", 32'(d_rvalid), 0);
    check("t6_rready", 32'(rready), 0);
    check("t6_i_arready", 32'(i_arready), 0);
    check("t6_awvalid", 32'(awvalid), 0);
    check("t6_wvalid", 32'(wvalid), 0);
    check("t6_d_bvalid", 32'(d_bvalid), 0);
    @(posedge clk); #1;
    do_read(1, 32'h0000_6000, 8'd1, 0, "t6new");

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
